// File: rtl/supersonic_pkg.sv
// rtl/supersonic_pkg.sv - shared types and defaults for the supersonic ranging controller
package supersonic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    WAIT_ECHO,
    MEASURE
  } state_t;

  localparam logic [31:0] TIMEOUT_DIST = 32'hFFFF_FFFF;

  localparam int unsigned TRIG_CYCLES_DEF  = 500;
  localparam int unsigned ECHO_TIMEOUT_DEF = 1_250_000;
  localparam int unsigned DIST_MUL_DEF     = 3512;
  localparam int unsigned DIST_SHIFT_DEF   = 10;

endpackage

// File: rtl/supersonic_sync2.sv
// rtl/supersonic_sync2.sv - two-flop synchronizer for an asynchronous level input
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/supersonic.sv
// rtl/supersonic.sv - trigger qualification, echo width measurement and distance conversion
module supersonic
  import supersonic_pkg::*;
#(
  parameter int unsigned TRIG_CYCLES  = TRIG_CYCLES_DEF,
  parameter int unsigned ECHO_TIMEOUT = ECHO_TIMEOUT_DEF,
  parameter int unsigned DIST_MUL     = DIST_MUL_DEF,
  parameter int unsigned DIST_SHIFT   = DIST_SHIFT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger,
  input  logic        echo,
  output logic        valid,
  output logic        triggerSuc,
  output logic [31:0] distance
);

  logic        trig_s;
  logic        echo_s;
  state_t      state;
  logic [31:0] cnt;
  logic [31:0] cnt_inc;
  logic [31:0] dist_calc;

  sync2 u_sync_trig (.clk(clk), .rst_n(rst_n), .d(trigger), .q(trig_s));
  sync2 u_sync_echo (.clk(clk), .rst_n(rst_n), .d(echo),    .q(echo_s));

  assign cnt_inc   = cnt + 32'd1;
  // Product kept at 48 bits so long pulses do not overflow before the shift.
  assign dist_calc = 32'((48'(cnt) * 48'(DIST_MUL)) >> DIST_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      valid      <= 1'b0;
      triggerSuc <= 1'b0;
      distance   <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_s) begin
            if (cnt_inc >= 32'(TRIG_CYCLES)) begin
              state      <= WAIT_ECHO;
              triggerSuc <= 1'b1;
              cnt        <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end else begin
            cnt <= '0;
          end
        end
        WAIT_ECHO: begin
          if (echo_s) begin
            state <= MEASURE;
            cnt   <= 32'd1;
          end else if (cnt_inc >= 32'(ECHO_TIMEOUT)) begin
            state      <= IDLE;
            cnt        <= '0;
            valid      <= 1'b1;
            triggerSuc <= 1'b0;
            distance   <= TIMEOUT_DIST;
          end else begin
            cnt <= cnt_inc;
          end
        end
        MEASURE: begin
          if (!echo_s) begin
            state      <= IDLE;
            cnt        <= '0;
            valid      <= 1'b1;
            triggerSuc <= 1'b0;
            distance   <= dist_calc;
          end else if (cnt_inc >= 32'(ECHO_TIMEOUT)) begin
            state      <= IDLE;
            cnt        <= '0;
            valid      <= 1'b1;
            triggerSuc <= 1'b0;
            distance   <= TIMEOUT_DIST;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_supersonic.sv
// tb/tb_supersonic.sv - self-checking bench for supersonic with a pulse-level reference model
module tb_supersonic;

  localparam int TRIG = 500;
  localparam int TO   = 3000;
  localparam int MUL  = 3512;
  localparam int SH   = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trigger = 1'b0;
  logic        echo = 1'b0;
  logic        valid;
  logic        triggerSuc;
  logic [31:0] distance;

  int errors = 0;
  int checks = 0;
  int vcount = 0;
  bit run = 1'b0;

  supersonic #(
    .TRIG_CYCLES(TRIG), .ECHO_TIMEOUT(TO), .DIST_MUL(MUL), .DIST_SHIFT(SH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .echo(echo),
    .valid(valid), .triggerSuc(triggerSuc), .distance(distance)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sees each input two edges late, then applies the ranging rules.
  logic [1:0]  th, eh;
  int          run_len, waited, width;
  bit          busy;
  logic        m_valid, m_suc;
  logic [31:0] m_dist;

  task automatic model_reset();
    th = '0; eh = '0; run_len = 0; waited = 0; width = 0; busy = 0;
    m_valid = 0; m_suc = 0; m_dist = '0;
  endtask

  task automatic model_finish(input logic [31:0] d);
    m_valid = 1; m_suc = 0; m_dist = d; busy = 0; run_len = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        logic ts, es;
        ts = th[1]; es = eh[1];
        th = {th[0], trigger}; eh = {eh[0], echo};
        m_valid = 0;
        if (!busy) begin
          run_len = ts ? run_len + 1 : 0;
          if (run_len == TRIG) begin
            busy = 1; m_suc = 1; run_len = 0; waited = 0; width = 0;
          end
        end else if (width == 0) begin
          if (es) width = 1;
          else begin
            waited++;
            if (waited >= TO) model_finish(32'hFFFF_FFFF);
          end
        end else if (es) begin
          width++;
          if (width >= TO) model_finish(32'hFFFF_FFFF);
        end else begin
          model_finish(32'(((64'(width) * 64'(MUL)) >> SH)));
        end
      end
    end
  end

  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (run) begin
      chk("valid", {31'd0, valid}, {31'd0, m_valid});
      chk("trigger_suc", {31'd0, triggerSuc}, {31'd0, m_suc});
      chk("distance", distance, m_dist);
      chk("valid_not_back_to_back", {31'd0, prev_valid & valid}, 32'd0);
      if (valid) vcount++;
      prev_valid <= valid;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_trig(input int n);
    trigger = 1'b1; step(n); trigger = 1'b0;
  endtask

  task automatic pulse_echo(input int n);
    echo = 1'b1; step(n); echo = 1'b0;
  endtask

  task automatic measure(input int en, input logic [31:0] exp_d, input string name);
    int v0;
    v0 = vcount;
    pulse_trig(TRIG);
    step(5);
    chk({name, "_armed"}, {31'd0, triggerSuc}, 32'd1);
    pulse_echo(en);
    step(6);
    chk({name, "_dist"}, distance, exp_d);
    chk({name, "_pulses"}, 32'(vcount - v0), 32'd1);
    chk({name, "_suc_low"}, {31'd0, triggerSuc}, 32'd0);
  endtask

  initial begin
    int v0;
    step(3);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_suc", {31'd0, triggerSuc}, 32'd0);
    chk("reset_dist", distance, 32'd0);
    rst_n = 1'b1;
    run = 1'b1;
    step(3);

    measure(25, 32'd85, "w25");

    // Reset so the short-trigger case starts from distance 0.
    rst_n = 1'b0; step(2); rst_n = 1'b1; step(2);
    v0 = vcount;
    pulse_trig(TRIG - 1);
    step(5);
    chk("short_trig_suc", {31'd0, triggerSuc}, 32'd0);
    pulse_echo(25);
    step(8);
    chk("short_trig_pulses", 32'(vcount - v0), 32'd0);
    chk("short_trig_dist", distance, 32'd0);

    measure(1000, 32'd3429, "w1000");

    v0 = vcount;
    pulse_trig(TRIG);
    step(TO + 10);
    chk("timeout_dist", distance, 32'hFFFF_FFFF);
    chk("timeout_pulses", 32'(vcount - v0), 32'd1);
    chk("timeout_suc", {31'd0, triggerSuc}, 32'd0);

    pulse_trig(TRIG);
    step(5);
    echo = 1'b1;
    step(10);
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", {31'd0, valid}, 32'd0);
    chk("midreset_suc", {31'd0, triggerSuc}, 32'd0);
    chk("midreset_dist", distance, 32'd0);
    step(3);
    echo = 1'b0;
    rst_n = 1'b1;
    step(5);
    measure(25, 32'd85, "after_reset");

    measure(25, 32'd85, "b2b_first");
    measure(50, 32'd171, "b2b_second");

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/supersonic.md
Name: supersonic

Overview:
Ultrasonic ranging controller for an HC-SR04-style sensor path.
- Qualifies a host trigger request that must be held for a minimum pulse width.
- Measures the width of the returning echo pulse in clock cycles.
- Converts the width to distance in micrometres.
- Presents the result with a one-cycle valid strobe to the downstream display/control logic.

Parameters:
TRIG_CYCLES, 500, consecutive high cycles of trigger needed to qualify a request (10 us at 50 MHz)
ECHO_TIMEOUT, 1_250_000, max cycles allowed waiting for echo rise, and max echo-high cycles
DIST_MUL, 3512, fixed-point multiplier µm per cycle ×2^DIST_SHIFT (≈3.43 µm/cycle at 50 MHz)
DIST_SHIFT, 10, right shift applied after multiply

Ports:
clk  input  1  system clock (50 MHz nominal)
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
trigger  input  1  measurement request level, asynchronous to clk
echo  input  1  sensor echo pulse, asynchronous to clk
valid  output  1  one-cycle strobe: distance updated
triggerSuc  output  1  high while a qualified request is in progress
distance  output  32  last measured distance in µm; holds between measurements

Behaviour:
- Reset values: valid=0, triggerSuc=0, distance=0, FSM=IDLE, counters=0, synchronizer flops=0.
- Input synchronization: trigger and echo each pass through a 2-flop synchronizer. The FSM uses only the synced signals (trig_s, echo_s). X/unknown inputs before first drive are harmless after reset.
- FSM states: IDLE, ARMED, WAIT_ECHO, MEASURE.
- IDLE:
  - Counter counts consecutive cycles with trig_s=1.
  - trig_s=0 clears the counter.
  - On the edge where the count reaches TRIG_CYCLES, go to WAIT_ECHO, set triggerSuc=1, clear the counter.
- WAIT_ECHO:
  - Counter increments each cycle.
  - echo_s=1 → MEASURE, counter loaded with 1 (that cycle counts).
  - Counter reaching ECHO_TIMEOUT → timeout.
- MEASURE:
  - Counter increments while echo_s=1.
  - echo_s=0 → distance <= (count × DIST_MUL) >> DIST_SHIFT, computed at 48-bit width and truncated to 32. valid=1 for that one cycle, triggerSuc=0, go to IDLE.
  - count reaching ECHO_TIMEOUT → timeout.
- Timeout: distance <= 32'hFFFF_FFFF, valid pulses one cycle, triggerSuc=0, go to IDLE.
- The trigger level is ignored outside IDLE. A trigger still held high after returning to IDLE must be re-qualified: the counter restarts from 0, so a full TRIG_CYCLES of high samples is needed again.
- Echo activity while in IDLE is ignored.
- Count = number of rising clk edges at which echo_s was high, equal to the echo pulse width in cycles.
- Latency: valid rises on the 3rd rising edge after the first edge that samples echo low (2 synchronizer stages + FSM). valid is never high 2 cycles in a row.
- distance changes only on cycles where valid=1.
- Reset mid-operation aborts immediately to the reset values above.

Decomposition:
- Shared package supersonic_pkg: FSM state enum (IDLE, ARMED, WAIT_ECHO, MEASURE), TIMEOUT_DIST constant 32'hFFFF_FFFF, parameter defaults.
- One sub-module, sync2: 2-flop synchronizer with asynchronous active-low reset, instantiated twice (trigger, echo).

Test Plan:
- trigger high 500 cycles then low, echo high 25 cycles → triggerSuc rises after 500 synced samples; one valid pulse with distance = (25×3512)>>10 = 85.
- trigger high only 499 cycles, then echo pulse → triggerSuc stays 0, no valid, distance stays 0.
- Qualified trigger, echo high 1000 cycles → valid once, distance = 3429.
- Qualified trigger, echo never rises → after ECHO_TIMEOUT cycles valid pulses with distance 32'hFFFF_FFFF, triggerSuc=0.
- rst_n asserted during MEASURE → valid, triggerSuc, distance immediately 0. A following full measurement (500/25) yields 85.
- Two back-to-back measurements (echo 25 then 50 cycles) → distance 85 then 171, exactly one valid pulse each, triggerSuc drops after each.
